// File: rtl/alu_arbiter_if.sv
// Bundles the request, ALU and response signals of alu_arbiter.
// slave is the arbiter's view; master is the surrounding datapath's view.
interface alu_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_zero;
  logic             alu_negative;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_carry, alu_overflow, alu_zero, alu_negative,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_carry, alu_overflow, alu_zero, alu_negative,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a single
// registered, backpressured, tagged response slot.
module alu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          RESET_PRIO = 1'b0
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt_valid;
  logic             gnt_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic             sel_legal;
  logic             slot_free;
  logic             ready0;
  logic             ready1;
  logic             accept;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  always_comb begin
    gnt_valid = bus.req0_valid | bus.req1_valid;
    gnt_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = prio_q;
    end else if (bus.req1_valid) begin
      gnt_id = 1'b1;
    end

    sel_a  = '0;
    sel_b  = '0;
    sel_op = 3'b000;
    if (gnt_valid) begin
      sel_a  = gnt_id ? bus.req1_a  : bus.req0_a;
      sel_b  = gnt_id ? bus.req1_b  : bus.req0_b;
      sel_op = gnt_id ? bus.req1_op : bus.req0_op;
    end
    sel_legal = op_legal(sel_op);

    bus.alu_a    = sel_a;
    bus.alu_b    = sel_b;
    bus.alu_ctrl = sel_legal ? sel_op : 3'b000;

    // rst gating keeps both readies low while reset is held.
    slot_free = (state_q == EMPTY) | bus.rsp_ready;
    ready0    = rst & slot_free & bus.req0_valid & ~gnt_id;
    ready1    = rst & slot_free & bus.req1_valid & gnt_id;
    accept    = ready0 | ready1;

    bus.req0_ready = ready0;
    bus.req1_ready = ready1;
  end

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (bus.rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      rsp_id_d = gnt_id;
      prio_d   = ~gnt_id;
      if (sel_legal) begin
        rsp_result_d = bus.alu_result;
        rsp_flags_d  = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
        rsp_err_d    = 1'b0;
      end else begin
        rsp_result_d = '0;
        rsp_flags_d  = '0;
        rsp_err_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= EMPTY;
      prio_q       <= RESET_PRIO;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    bus.rsp_valid  = (state_q == FULL);
    bus.rsp_id     = rsp_id_q;
    bus.rsp_result = rsp_result_q;
    bus.rsp_flags  = rsp_flags_q;
    bus.rsp_err    = rsp_err_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural RV32I ALU attached.
module tb_alu_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  rsp_t sb[$];

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32), .RESET_PRIO(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU driven by the arbiter's muxed operands.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum          = '0;
    bus.alu_result   = '0;
    bus.alu_carry    = 1'b0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_ctrl)
      3'b000: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_result   = alu_sum[31:0];
        bus.alu_carry    = alu_sum[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
      3'b001: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_result   = alu_sum[31:0];
        bus.alu_carry    = alu_sum[32];
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (alu_sum[31] != bus.alu_a[31]);
      end
      3'b010: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b101: bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero     = (bus.alu_result == 32'd0);
    bus.alu_negative = bus.alu_result[31];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rsp_t ref_rsp(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
    rsp_t            e;
    longint          sa, sb_v, sr;
    longint unsigned ua, ub;
    logic            c, v;
    e    = '0;
    e.id = id;
    c    = 1'b0;
    v    = 1'b0;
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    sa   = $signed(a);
    sb_v = $signed(b);
    case (op)
      3'b000: begin
        e.result = a + b;
        sr = sa + sb_v;
        c  = (ua + ub) > 64'hFFFF_FFFF;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b001: begin
        e.result = a - b;
        sr = sa - sb_v;
        c  = (ua >= ub);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'b010: e.result = a & b;
      3'b011: e.result = a | b;
      3'b101: e.result = (sa < sb_v) ? 32'd1 : 32'd0;
      default: begin
        e.err = 1'b1;
        return e;
      end
    endcase
    e.flags = {e.result[31], e.result == 32'd0, c, v};
    return e;
  endfunction

  // Responses are popped before new accepts are pushed on the same edge.
  always @(negedge clk) begin
    rsp_t e;
    if (rst) begin
      check("one_ready", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", {63'd0, bus.rsp_id}, {63'd0, e.id});
          check("rsp_result", {32'd0, bus.rsp_result}, {32'd0, e.result});
          check("rsp_flags", {60'd0, bus.rsp_flags}, {60'd0, e.flags});
          check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e.err});
        end
      end
      if (bus.req0_valid && bus.req0_ready)
        sb.push_back(ref_rsp(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
      if (bus.req1_valid && bus.req1_ready)
        sb.push_back(ref_rsp(1'b1, bus.req1_a, bus.req1_b, bus.req1_op));
    end
  end

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req0_valid = v;
    bus.req0_a     = a;
    bus.req0_b     = b;
    bus.req0_op    = op;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus.req1_valid = v;
    bus.req1_a     = a;
    bus.req1_b     = b;
    bus.req1_op    = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 sb.delete();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req0(1'b1, 32'd1, 32'd1, 3'b000);
    set_req1(1'b0, '0, '0, 3'b000);
    #3;
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
    check("rst_rsp_result", {32'd0, bus.rsp_result}, 64'd0);
    check("rst_rsp_flags", {60'd0, bus.rsp_flags}, 64'd0);
    check("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
    check("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    step();
    rst = 1'b1;
    set_req0(1'b0, '0, '0, 3'b000);

    // Single ADD from requester 0
    step();
    set_req0(1'b1, 32'd2, 32'd2, 3'b000);
    #2;
    check("add_ready0", {63'd0, bus.req0_ready}, 64'd1);
    check("add_alu_a", {32'd0, bus.alu_a}, 64'd2);
    check("add_alu_ctrl", {61'd0, bus.alu_ctrl}, 64'd0);
    step();
    set_req0(1'b0, '0, '0, 3'b000);
    #2;
    check("add_latency", {63'd0, bus.rsp_valid}, 64'd1);
    check("add_result", {32'd0, bus.rsp_result}, 64'd4);

    // Fairness under continuous dual requests
    reset_dut();
    set_req0(1'b1, 32'd5, 32'd2, 3'b001);
    set_req1(1'b1, 32'd2, 32'd5, 3'b101);
    for (int i = 0; i < 6; i++) begin
      #2;
      check("fair_ready0", {63'd0, bus.req0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      check("fair_ready1", {63'd0, bus.req1_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
      step();
    end
    set_req0(1'b0, '0, '0, 3'b000);
    set_req1(1'b0, '0, '0, 3'b000);
    step();

    // Signed overflow on ADD
    set_req0(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b000);
    step();
    set_req0(1'b0, '0, '0, 3'b000);
    #2;
    check("ovf_result", {32'd0, bus.rsp_result}, 64'h8000_0000);
    check("ovf_flags", {60'd0, bus.rsp_flags}, 64'h9);
    step();

    // Backpressure: response held, req1 pending
    set_req0(1'b1, 32'hF0, 32'h3C, 3'b010);
    step();
    set_req0(1'b0, '0, '0, 3'b000);
    bus.rsp_ready = 1'b0;
    set_req1(1'b1, 32'd5, 32'd2, 3'b011);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("stall_ready0", {63'd0, bus.req0_ready}, 64'd0);
      check("stall_ready1", {63'd0, bus.req1_ready}, 64'd0);
      check("stall_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("stall_id", {63'd0, bus.rsp_id}, 64'd0);
      check("stall_result", {32'd0, bus.rsp_result}, 64'h30);
      step();
    end
    bus.rsp_ready = 1'b1;
    #2;
    check("unstall_ready1", {63'd0, bus.req1_ready}, 64'd1);
    step();
    set_req1(1'b0, '0, '0, 3'b000);
    #2;
    check("unstall_id", {63'd0, bus.rsp_id}, 64'd1);
    check("unstall_result", {32'd0, bus.rsp_result}, 64'd7);
    step();

    // Illegal op code from requester 1
    set_req1(1'b1, 32'd9, 32'd3, 3'b110);
    #2;
    check("illegal_alu_ctrl", {61'd0, bus.alu_ctrl}, 64'd0);
    check("illegal_alu_a", {32'd0, bus.alu_a}, 64'd9);
    check("illegal_ready1", {63'd0, bus.req1_ready}, 64'd1);
    step();
    set_req1(1'b0, '0, '0, 3'b000);
    #2;
    check("illegal_err", {63'd0, bus.rsp_err}, 64'd1);
    check("illegal_id", {63'd0, bus.rsp_id}, 64'd1);
    step();

    // Asynchronous reset with a held response and a pending request
    bus.rsp_ready = 1'b0;
    set_req0(1'b1, 32'd1, 32'd1, 3'b000);
    step();
    set_req0(1'b0, '0, '0, 3'b000);
    set_req1(1'b1, 32'd10, 32'd1, 3'b000);
    #2;
    check("pre_rst_valid", {63'd0, bus.rsp_valid}, 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("async_rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    check("async_rst_result", {32'd0, bus.rsp_result}, 64'd0);
    sb.delete();
    step();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req0(1'b1, 32'd3, 32'd4, 3'b000);
    #2;
    check("post_rst_ready0", {63'd0, bus.req0_ready}, 64'd1);
    check("post_rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    step();
    #2;
    check("post_rst_next_ready1", {63'd0, bus.req1_ready}, 64'd1);
    check("post_rst_next_ready0", {63'd0, bus.req0_ready}, 64'd0);
    step();
    set_req0(1'b0, '0, '0, 3'b000);
    set_req1(1'b0, '0, '0, 3'b000);
    repeat (3) step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single RV32I ALU between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-target helper.
- Requests arrive on a valid/ready handshake and are granted round-robin.
- The block drives the ALU operand and control inputs combinationally and samples result and flags in the same cycle.
- It returns one tagged, registered response per accepted request on a single backpressured response channel.

Parameters:
- WIDTH, 32, operand/result width.
- RESET_PRIO, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  3  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_ctrl  output  3  to ALU ALUControl.
- alu_result  input  WIDTH  from ALU Result.
- alu_carry  input  1  from ALU Carry.
- alu_overflow  input  1  from ALU OverFlow.
- alu_zero  input  1  from ALU Zero.
- alu_negative  input  1  from ALU Negative.
- rsp_valid  output  1  response register holds data.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester the response belongs to.
- rsp_result  output  WIDTH  registered result.
- rsp_flags  output  4  {negative, zero, carry, overflow}.
- rsp_err  output  1  illegal op code.

Behaviour:
- Reset (rst=0, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0.
  - Priority pointer = RESET_PRIO.
  - Any pending response is dropped.
  - req*_ready evaluate to 0 while in reset.
- Legal op codes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
  - 100, 110 and 111 are illegal.
- slot_free = ~rsp_valid | rsp_ready.
- Grant (combinational):
  - Only one valid requester: that requester wins.
  - Both valid: the requester named by the priority pointer wins.
  - Neither valid: no grant.
- Ready rule: reqN_ready = slot_free & grant==N & reqN_valid. At most one ready is high per cycle.
- ALU drive:
  - alu_a, alu_b and alu_ctrl are muxed from the granted requester.
  - With no grant: drive 0, 0, 000.
  - With an illegal op: drive alu_ctrl=000; operands pass through.
- Capture on an accepted handshake (reqN_valid & reqN_ready at the posedge):
  - rsp_valid<=1, rsp_id<=N.
  - Legal op: rsp_result<=alu_result, rsp_flags<={alu_negative, alu_zero, alu_carry, alu_overflow}, rsp_err<=0.
  - Illegal op: rsp_result<=0, rsp_flags<=0, rsp_err<=1.
  - Priority pointer <= ~N.
- Latency and throughput:
  - Latency is 1 cycle: rsp_valid is high the cycle after the request handshake.
  - Throughput is 1 op/cycle while rsp_ready=1.
- Response hold:
  - rsp_valid=1 & rsp_ready=0: all rsp_* hold stable, both req*_ready=0, the pointer does not change.
  - rsp_valid=1 & rsp_ready=1 with a new accept in the same cycle: the register reloads with the new response and rsp_valid stays 1.
  - rsp_valid=1 & rsp_ready=1 with no accept: rsp_valid<=0; data registers hold their last value.
- Requester protocol: requesters hold a, b and op stable while valid & ~ready. A requester may drop valid without being accepted; the block tolerates this with no side effects.
- Fairness: under continuous dual requests with rsp_ready=1, grants alternate 0,1,0,1. Neither requester waits more than one grant.
- State:
  - Two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1), plus the 1-bit priority pointer.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on rsp_ready with no accept.
  - FULL→FULL on accept, or while stalled.

Test Plan:
- Reset, then req0 ADD A=2, B=2 alone → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=4, rsp_flags=0000, rsp_err=0.
- Both requesters valid every cycle with rsp_ready=1, req0 SUB 5,2 and req1 SLT 2,5, RESET_PRIO=0 → responses alternate id 0 (result 3) / id 1 (result 1), one per cycle.
- req0 ADD 0x7FFFFFFF+1 → rsp_result=0x80000000, rsp_flags=1001 (N=1, V=1).
- rsp_ready=0 for 3 cycles with req1 OR 5,2 pending behind a held response → both readies stay 0, rsp_* stable; on rsp_ready=1, req1 accepted same cycle and the next response is 7 with id 1.
- req1 op=110 → alu_ctrl=000; response id 1, rsp_err=1, rsp_result=0, rsp_flags=0.
- Assert rst=0 asynchronously mid-cycle while rsp_valid=1 and a request is pending → rsp_valid drops immediately; after release the pointer equals RESET_PRIO and the first dual request is granted to requester RESET_PRIO.
